// File: rtl/alu_pkg.sv
// Shared ALU datapath types: default operand width and the result flag bundle.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } flags_t;

  localparam flags_t FLAGS_CLR = '{cout: 1'b0, ovf: 1'b0, zero: 1'b0};

endpackage

// File: rtl/addsub_slice.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its top bit
// so the final slice can form signed overflow. Zero latency, no handshake.
module addsub_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic c;

  always_comb begin
    c      = cin_i;
    cmsb_o = cin_i;
    sum_o  = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) cmsb_o = c;
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/sub: one CHUNK per stage, carry registered between stages.
// Latency STAGES cycles, 1 op/cycle; a stalled output freezes every stage (in_ready = advance).
module pipe_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int CHUNK = WIDTH / STAGES;

  if (WIDTH % STAGES != 0) begin : g_bad_cfg
    $error("pipe_addsub: WIDTH must be a multiple of STAGES");
  end

  logic adv;

  // Index k holds what stage k consumes: operands (B already inverted for sub),
  // incoming carry and the low-order sum chunks finished so far.
  logic             vld_in [STAGES];
  logic             cy_in  [STAGES];
  logic [WIDTH-1:0] a_in   [STAGES];
  logic [WIDTH-1:0] b_in   [STAGES];
  logic [WIDTH-1:0] sum_in [STAGES];

  logic             out_vld_q;
  logic [WIDTH-1:0] out_sum_q;
  flags_t           out_flg_q;

  assign adv      = !out_vld_q || out_ready;
  assign in_ready = adv;

  assign vld_in[0] = in_valid;
  assign a_in[0]   = in_a;
  assign b_in[0]   = in_sub ? ~in_b : in_b;
  assign cy_in[0]  = in_sub | in_cin;
  assign sum_in[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_cmsb;
    logic [WIDTH-1:0] sum_d;

    addsub_slice #(.CHUNK(CHUNK)) u_slice (
      .a_i    (a_in[k][k*CHUNK +: CHUNK]),
      .b_i    (b_in[k][k*CHUNK +: CHUNK]),
      .cin_i  (cy_in[k]),
      .sum_o  (chunk_sum),
      .cout_o (chunk_cout),
      .cmsb_o (chunk_cmsb)
    );

    always_comb begin
      sum_d                    = sum_in[k];
      sum_d[k*CHUNK +: CHUNK]  = chunk_sum;
    end

    if (k < STAGES - 1) begin : g_mid
      logic             vld_q;
      logic             cy_q;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] sum_q;

      // Bubbles shift along with valid ops; their data is never observed.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          vld_q <= 1'b0;
          cy_q  <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
          sum_q <= '0;
        end else if (adv) begin
          vld_q <= vld_in[k];
          cy_q  <= chunk_cout;
          a_q   <= a_in[k];
          b_q   <= b_in[k];
          sum_q <= sum_d;
        end
      end

      assign vld_in[k+1] = vld_q;
      assign cy_in[k+1]  = cy_q;
      assign a_in[k+1]   = a_q;
      assign b_in[k+1]   = b_q;
      assign sum_in[k+1] = sum_q;
    end else begin : g_last
      flags_t flg_d;

      always_comb begin
        flg_d = '{cout: chunk_cout, ovf: chunk_cout ^ chunk_cmsb, zero: (sum_d == '0)};
      end

      // Result registers load only for a real op so bubbles leave the last result visible.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          out_vld_q <= 1'b0;
          out_sum_q <= '0;
          out_flg_q <= FLAGS_CLR;
        end else if (adv) begin
          out_vld_q <= vld_in[k];
          if (vld_in[k]) begin
            out_sum_q <= sum_d;
            out_flg_q <= flg_d;
          end
        end
      end
    end
  end

  assign out_valid = out_vld_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_flg_q.cout;
  assign out_ovf   = out_flg_q.ovf;
  assign out_zero  = out_flg_q.zero;

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: directed corner ops plus randomized streams on STAGES=1/4/8
// instances, scored against an arithmetic reference model.
module tb_pipe_addsub;

  localparam int W = 32;

  typedef logic [W+2:0] res_t;  // {sum, cout, ovf, zero}

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         in_cin;
  logic         out_ready;

  logic         in_valid_v  [3];
  logic         in_ready_v  [3];
  logic         out_valid_v [3];
  logic [W-1:0] sum_v       [3];
  logic         cout_v      [3];
  logic         ovf_v       [3];
  logic         zero_v      [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_addsub #(.WIDTH(W), .STAGES(1)) u_s1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_sum(sum_v[0]),
    .out_cout(cout_v[0]), .out_ovf(ovf_v[0]), .out_zero(zero_v[0])
  );

  pipe_addsub #(.WIDTH(W), .STAGES(4)) u_s4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_sum(sum_v[1]),
    .out_cout(cout_v[1]), .out_ovf(ovf_v[1]), .out_zero(zero_v[1])
  );

  pipe_addsub #(.WIDTH(W), .STAGES(8)) u_s8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(out_valid_v[2]), .out_ready(out_ready), .out_sum(sum_v[2]),
    .out_cout(cout_v[2]), .out_ovf(ovf_v[2]), .out_zero(zero_v[2])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Integer-arithmetic model: flags come from the mathematical result, not from carries.
  function automatic res_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic sub, input logic cin);
    longint ua   = a;
    longint ub   = b;
    longint sa   = $signed(a);
    longint sb   = $signed(b);
    longint smax = (longint'(1) <<< (W - 1)) - 1;
    longint smin = -(longint'(1) <<< (W - 1));
    longint full;
    longint sfull;
    logic [W-1:0] s;
    logic co;
    logic ov;
    if (sub) begin
      full  = ua - ub;
      sfull = sa - sb;
      co    = (ua >= ub);
    end else begin
      full  = ua + ub + longint'(cin);
      sfull = sa + sb + longint'(cin);
      co    = (full >= (longint'(1) <<< W));
    end
    s  = full[W-1:0];
    ov = (sfull > smax) || (sfull < smin);
    return {s, co, ov, (s == '0)};
  endfunction

  function automatic res_t dut_res(input int i);
    return {sum_v[i], cout_v[i], ovf_v[i], zero_v[i]};
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One op into the STAGES=4 instance with an open sink; checks latency and result.
  task automatic single_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub, input logic cin, input res_t exp);
    int lat;
    tick();
    in_a = a; in_b = b; in_sub = sub; in_cin = cin;
    in_valid_v[1] = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, in_ready_v[1], 1);
    tick();
    in_valid_v[1] = 1'b0;
    lat = 1;
    #1;
    while (!out_valid_v[1] && lat < 20) begin
      tick();
      #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_res"}, dut_res(1), exp);
  endtask

  // Scoreboarded stream of n ops. rnd=0: in_valid held high, sink stalled on cycles 5-7.
  task automatic stream(input int sel, input int n, input bit rnd);
    res_t q[$];
    int acc  = 0;
    int done = 0;
    int cyc  = 0;
    while ((acc < n || q.size() > 0) && cyc < 40 * n + 100) begin
      tick();
      in_valid_v[sel] = (acc < n) && (rnd ? ($urandom_range(3) != 0) : 1'b1);
      in_a   = rand_op();
      in_b   = rand_op();
      in_sub = 1'($urandom_range(1));
      in_cin = 1'($urandom_range(1));
      out_ready = rnd ? ($urandom_range(9) < 7) : !(cyc >= 5 && cyc <= 7);
      #1;
      chk("in_ready", in_ready_v[sel], !out_valid_v[sel] || out_ready);
      if (out_valid_v[sel]) begin
        if (q.size() == 0) begin
          chk("spurious_vld", out_valid_v[sel], 0);
        end else begin
          chk("result", dut_res(sel), q[0]);
          if (out_ready) begin
            void'(q.pop_front());
            done++;
          end
        end
      end
      if (in_valid_v[sel] && in_ready_v[sel]) begin
        q.push_back(ref_model(in_a, in_b, in_sub, in_cin));
        acc++;
      end
      cyc++;
    end
    in_valid_v[sel] = 1'b0;
    chk("count", done, n);
    chk("drained", q.size(), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) in_valid_v[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_rdy", in_ready_v[i], 1);
      chk("rst_vld", out_valid_v[i], 0);
      chk("rst_out", dut_res(i), 0);
    end
    reset_n = 1'b1;

    single_op("add_chunk_carry", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0,
              {32'h0001_0000, 1'b0, 1'b0, 1'b0});
    single_op("sub_ovf", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0,
              {32'h8000_0000, 1'b0, 1'b1, 1'b0});
    single_op("sub_zero", 32'd5, 32'd5, 1'b1, 1'b1,
              {32'h0000_0000, 1'b1, 1'b0, 1'b1});
    single_op("full_carry", 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1,
              {32'h0000_0000, 1'b1, 1'b0, 1'b1});

    stream(1, 8, 1'b0);

    // Three ops in flight, then a one-cycle reset pulse.
    for (int i = 0; i < 3; i++) begin
      tick();
      in_a = rand_op(); in_b = rand_op(); in_sub = 1'b0; in_cin = 1'b0;
      in_valid_v[1] = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("mid_rdy", in_ready_v[1], 1);
    end
    tick();
    in_valid_v[1] = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_vld", out_valid_v[1], 0);
    chk("mid_rst_out", dut_res(1), 0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_rst_vld", out_valid_v[1], 0);
    end
    single_op("post_rst", 32'h1234_5678, 32'h0000_0008, 1'b1, 1'b0,
              {32'h1234_5670, 1'b1, 1'b0, 1'b0});

    stream(0, 1000, 1'b1);
    stream(1, 1000, 1'b1);
    stream(2, 1000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
